pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port ck_i, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rs_n_i, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port stallreq_if_i, input, 1, fetch stage requests a stall.
REQ-004 SHALL have port stallreq_id_i, input, 1, decode stage requests a stall (load-use hazard).
REQ-005 SHALL have port stallreq_ex_i, input, 1, execute stage requests a stall (multi-cycle op).
REQ-006 SHALL have port stallreq_mem_i, input, 1, LSU requests a stall (bus wait).
REQ-007 SHALL have port mem_busy_i, input, 1, an LSU bus transaction is outstanding.
REQ-008 SHALL have port trap_req_i, input, 1, trap/exception/mret taken in MEM stage.
REQ-009 SHALL have port trap_pc_i, input, 32, trap target PC.
REQ-010 SHALL have port branch_req_i, input, 1, EX-stage taken branch/jump.
REQ-011 SHALL have port branch_pc_i, input, 32, branch target PC.
REQ-012 SHALL have port stall_o, output, 6, per-stage stall vector: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = STOP.
REQ-013 SHALL have port flush_o, output, 1, pipeline-register flush pulse.
REQ-014 SHALL have port new_pc_o, output, 32, redirect PC, valid while flush_o=1.
REQ-015 SHALL have port stall_cnt_o, output, 32, count of cycles with stall_o[0]=1.

Function
REQ-016 SHALL implement FSM states IDLE, DRAIN, FLUSH, held in a state register.
REQ-017 In IDLE, stall_o SHALL be combinational from requests; highest-priority source wins: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, if -> 6'b000011, none -> 6'b000000.
REQ-018 IDLE: trap_req_i=1 and mem_busy_i=0 SHALL latch trap_pc_i and go to FLUSH next cycle.
REQ-019 IDLE: trap_req_i=1 and mem_busy_i=1 SHALL latch trap_pc_i and go to DRAIN.
REQ-020 IDLE: branch_req_i=1 with trap_req_i=0 SHALL latch branch_pc_i and go to FLUSH; a simultaneous trap SHALL win and the branch SHALL be dropped.
REQ-021 DRAIN: stall_o SHALL be 6'b011111; trap_req_i and branch_req_i SHALL be ignored; the first latched PC SHALL be kept.
REQ-022 DRAIN: mem_busy_i=0 sampled SHALL move to FLUSH next cycle.
REQ-023 FLUSH: flush_o=1 and new_pc_o = latched PC for exactly one cycle; stall_o SHALL be 6'b000000; next state SHALL be IDLE unconditionally.
REQ-024 flush_o and new_pc_o SHALL be registered outputs; flush_o=0 in IDLE and DRAIN; new_pc_o SHALL hold its last value when flush_o=0.
REQ-025 Redirect latency SHALL be 1 cycle from request to flush_o (no bus busy), or 1 cycle after mem_busy_i falls (DRAIN).
REQ-026 stall_cnt_o SHALL increment by 1 each cycle stall_o[0]=1, wrap from 32'hFFFFFFFF to 0, and hold otherwise.
REQ-027 Requests arriving in FLUSH SHALL be ignored; the issuing stage is flushed and re-requests after refetch.

Reset
REQ-028 While rs_n_i=0, the block SHALL immediately force state=IDLE, flush_o=0, new_pc_o=32'h0, stall_cnt_o=0, latched PC=0, independent of ck_i.
REQ-029 Reset asserted in DRAIN or FLUSH SHALL abort the pending redirect; no flush_o pulse SHALL follow deassertion.
REQ-030 During reset, stall_o SHALL be 6'b000000 regardless of request inputs.

Verification
REQ-031 Priority: stallreq_id_i=1 and stallreq_mem_i=1 together -> stall_o=6'b011111; id alone -> 6'b000111; none -> 6'b000000.
REQ-032 Fast trap: trap_req_i=1, trap_pc_i=32'h8000_0100, mem_busy_i=0 -> next cycle flush_o=1, new_pc_o=32'h8000_0100 for one cycle, then IDLE.
REQ-033 Drain: trap_req_i=1 (pc 32'h100) with mem_busy_i=1 for 3 more cycles; second trap (pc 32'h200) meanwhile -> stall_o=6'b011111 for 3 cycles, then one flush_o cycle with new_pc_o=32'h100.
REQ-034 Collision: trap (32'h300) and branch (32'h400) in the same cycle -> single flush_o, new_pc_o=32'h300.
REQ-035 Counter: stallreq_if_i held 5 cycles from stall_cnt_o=32'hFFFFFFFE -> stall_cnt_o=32'h3 after the fifth cycle.
REQ-036 Reset mid-DRAIN: rs_n_i low for 1 cycle while in DRAIN -> outputs cleared immediately; no flush_o after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for a six-stage in-order pipeline.
//
// Ports
//   ck_i           clock, all state updates on the rising edge
//   rs_n_i         asynchronous active-low reset
//   stallreq_if_i  fetch stage stall request
//   stallreq_id_i  decode stage stall request (load-use hazard)
//   stallreq_ex_i  execute stage stall request (multi-cycle op)
//   stallreq_mem_i LSU stall request (bus wait)
//   mem_busy_i     an LSU bus transaction is outstanding
//   trap_req_i     trap/exception/mret taken in MEM
//   trap_pc_i      trap target PC
//   branch_req_i   EX-stage taken branch/jump
//   branch_pc_i    branch target PC
//   stall_o        per-stage stall vector (bit0 PC .. bit5 WB), 1 = stop
//   flush_o        one-cycle pipeline-register flush pulse (registered)
//   new_pc_o       redirect PC, valid while flush_o=1, holds otherwise
//   stall_cnt_o    wrapping count of cycles with stall_o[0]=1
module pipe_ctrl (
  input  logic        ck_i,
  input  logic        rs_n_i,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        mem_busy_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_pc_i,
  input  logic        branch_req_i,
  input  logic [31:0] branch_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q;
  logic [31:0] new_pc_q;
  logic [31:0] stall_cnt_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    stall_o = 6'b000000;
    case (state_q)
      IDLE: begin
        if (stallreq_mem_i)     stall_o = 6'b011111;
        else if (stallreq_ex_i) stall_o = 6'b001111;
        else if (stallreq_id_i) stall_o = 6'b000111;
        else if (stallreq_if_i) stall_o = 6'b000011;

        // A trap outranks a same-cycle branch; the branch is simply dropped
        // because the trap redirect flushes the branching instruction anyway.
        if (trap_req_i) begin
          pc_d    = trap_pc_i;
          state_d = mem_busy_i ? DRAIN : FLUSH;
        end else if (branch_req_i) begin
          pc_d    = branch_pc_i;
          state_d = FLUSH;
        end
      end
      DRAIN: begin
        // Freeze everything up to MEM until the outstanding bus access
        // retires; later redirects are ignored so the first PC is kept.
        stall_o = 6'b011111;
        if (!mem_busy_i) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset dominates the combinational stall path as well.
    if (!rs_n_i) stall_o = 6'b000000;
  end

  always_ff @(posedge ck_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      state_q     <= IDLE;
      pc_q        <= 32'h0;
      flush_q     <= 1'b0;
      new_pc_q    <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      // flush_o is high exactly while the FSM sits in FLUSH.
      flush_q <= (state_d == FLUSH);
      if (state_d == FLUSH) new_pc_q <= pc_d;
      if (stall_o[0]) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign flush_o     = flush_q;
  assign new_pc_o    = new_pc_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
